configf_entity: RTL and testbench

//  Command executor downstream of the configf host stage. Accepts one command per
//  hst_cmd_en_in pulse: base address, direction and word count. Moves that many words

---
 rtl/configf_pkg.sv | 17 +
 rtl/configf_entity.sv | 139 +++++++++++++
 tb/tb_configf_entity.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/configf_pkg.sv
// Shared definitions for the configf command executor.
package configf_pkg;

  localparam int unsigned DIR_BIT = 7;
  localparam int unsigned CFG_AW  = 7;

  // One-hot state encoding
  typedef enum logic [5:0] {
    IDLE    = 6'b000001,
    WR_XFER = 6'b000010,
    RD_REQ  = 6'b000100,
    RD_WAIT = 6'b001000,
    RD_PUSH = 6'b010000,
    DONE    = 6'b100000
  } state_e;

endpackage

// File: rtl/configf_entity.sv
// Command executor: moves a block of words between the user write/read
// streams and the config register bus, then reports completion.
module configf_entity
  import configf_pkg::*;
#(
  parameter int unsigned DW        = 32,
  parameter int unsigned STALL_MAX = 1023
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              hst_cmd_en_in,
  input  logic [7:0]        hst_addr_in,
  input  logic [15:0]       hst_wrrd_num_in,
  output logic              hst_cmd_done_out,
  output logic              cmd_err_out,
  input  logic [DW-1:0]     wr_data_in,
  input  logic              wr_valid_in,
  output logic              wr_ready_out,
  output logic [DW-1:0]     rd_data_out,
  output logic              rd_valid_out,
  input  logic              rd_ready_in,
  output logic [CFG_AW-1:0] cfg_addr_out,
  output logic              cfg_wr_en_out,
  output logic [DW-1:0]     cfg_wr_data_out,
  output logic              cfg_rd_en_out,
  input  logic [DW-1:0]     cfg_rd_data_in
);

  // Abort fires on the idle cycle that brings the count to STALL_MAX
  localparam logic [9:0] StallLast = 10'(STALL_MAX - 1);

  state_e            state_q;
  logic [CFG_AW-1:0] cur_q;
  logic [15:0]       remain_q;
  logic [9:0]        stall_q;
  logic              err_q;

  // Command FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      cur_q            <= '0;
      remain_q         <= '0;
      stall_q          <= '0;
      err_q            <= 1'b0;
      hst_cmd_done_out <= 1'b0;
      cmd_err_out      <= 1'b0;
      wr_ready_out     <= 1'b0;
      rd_data_out      <= '0;
      rd_valid_out     <= 1'b0;
      cfg_addr_out     <= '0;
      cfg_wr_en_out    <= 1'b0;
      cfg_wr_data_out  <= '0;
      cfg_rd_en_out    <= 1'b0;
    end else begin
      cfg_wr_en_out    <= 1'b0;
      cfg_rd_en_out    <= 1'b0;
      hst_cmd_done_out <= 1'b0;
      cmd_err_out      <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (hst_cmd_en_in) begin
            cur_q    <= hst_addr_in[CFG_AW-1:0];
            remain_q <= hst_wrrd_num_in;
            err_q    <= 1'b0;
            stall_q  <= '0;
            if (hst_wrrd_num_in == 16'd0) begin
              state_q <= DONE;
            end else if (hst_addr_in[DIR_BIT]) begin
              state_q      <= WR_XFER;
              wr_ready_out <= 1'b1;
            end else begin
              // Read strobe is issued on entry so data lands in RD_WAIT
              state_q       <= RD_REQ;
              cfg_rd_en_out <= 1'b1;
              cfg_addr_out  <= hst_addr_in[CFG_AW-1:0];
            end
          end
        end
        WR_XFER: begin
          if (remain_q == 16'd0) begin
            // Last register write is on the bus this cycle
            state_q <= DONE;
          end else if (wr_valid_in) begin
            cfg_wr_en_out   <= 1'b1;
            cfg_addr_out    <= cur_q;
            cfg_wr_data_out <= wr_data_in;
            cur_q           <= cur_q + 7'd1;
            remain_q        <= remain_q - 16'd1;
            stall_q         <= '0;
            if (remain_q == 16'd1) wr_ready_out <= 1'b0;
          end else if (stall_q == StallLast) begin
            err_q        <= 1'b1;
            wr_ready_out <= 1'b0;
            state_q      <= DONE;
          end else begin
            stall_q <= stall_q + 10'd1;
          end
        end
        RD_REQ: begin
          state_q <= RD_WAIT;
        end
        RD_WAIT: begin
          rd_data_out  <= cfg_rd_data_in;
          rd_valid_out <= 1'b1;
          state_q      <= RD_PUSH;
        end
        RD_PUSH: begin
          if (rd_ready_in) begin
            rd_valid_out <= 1'b0;
            cur_q        <= cur_q + 7'd1;
            remain_q     <= remain_q - 16'd1;
            stall_q      <= '0;
            if (remain_q == 16'd1) begin
              state_q <= DONE;
            end else begin
              state_q       <= RD_REQ;
              cfg_rd_en_out <= 1'b1;
              cfg_addr_out  <= cur_q + 7'd1;
            end
          end else if (stall_q == StallLast) begin
            err_q        <= 1'b1;
            rd_valid_out <= 1'b0;
            state_q      <= DONE;
          end else begin
            stall_q <= stall_q + 10'd1;
          end
        end
        DONE: begin
          hst_cmd_done_out <= 1'b1;
          cmd_err_out      <= err_q;
          state_q          <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_configf_entity.sv
// Directed self-checking bench for configf_entity.
module tb_configf_entity;

  localparam int unsigned DW        = 32;
  localparam int unsigned STALL_MAX = 1023;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          hst_cmd_en_in;
  logic [7:0]    hst_addr_in;
  logic [15:0]   hst_wrrd_num_in;
  logic          hst_cmd_done_out;
  logic          cmd_err_out;
  logic [DW-1:0] wr_data_in;
  logic          wr_valid_in;
  logic          wr_ready_out;
  logic [DW-1:0] rd_data_out;
  logic          rd_valid_out;
  logic          rd_ready_in;
  logic [6:0]    cfg_addr_out;
  logic          cfg_wr_en_out;
  logic [DW-1:0] cfg_wr_data_out;
  logic          cfg_rd_en_out;
  logic [DW-1:0] cfg_rd_data_in;

  always #5 clk = ~clk;

  configf_entity #(.DW(DW), .STALL_MAX(STALL_MAX)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .hst_cmd_en_in    (hst_cmd_en_in),
    .hst_addr_in      (hst_addr_in),
    .hst_wrrd_num_in  (hst_wrrd_num_in),
    .hst_cmd_done_out (hst_cmd_done_out),
    .cmd_err_out      (cmd_err_out),
    .wr_data_in       (wr_data_in),
    .wr_valid_in      (wr_valid_in),
    .wr_ready_out     (wr_ready_out),
    .rd_data_out      (rd_data_out),
    .rd_valid_out     (rd_valid_out),
    .rd_ready_in      (rd_ready_in),
    .cfg_addr_out     (cfg_addr_out),
    .cfg_wr_en_out    (cfg_wr_en_out),
    .cfg_wr_data_out  (cfg_wr_data_out),
    .cfg_rd_en_out    (cfg_rd_en_out),
    .cfg_rd_data_in   (cfg_rd_data_in)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] reg_val(input logic [6:0] a);
    return {16'hDA7A, 9'h0, a};
  endfunction

  // Write stream source: words handed out in order, gated by wr_len
  logic [31:0] wr_src [16];
  int          wr_idx = 0;
  int          wr_len = 0;
  logic        wr_gate = 1'b0;
  assign wr_data_in  = wr_src[wr_idx % 16];
  assign wr_valid_in = wr_gate && (wr_idx < wr_len);

  // Monitor: log bus/stream events with the cycle they occur in
  int          cyc = 0;
  int          strobe_cyc = 0;
  logic [6:0]  w_addr_q [$];
  logic [31:0] w_data_q [$];
  int          w_cyc_q  [$];
  logic [6:0]  r_addr_q [$];
  logic [31:0] beat_q   [$];
  int          done_cyc_q [$];
  logic        done_err_q [$];
  int          hold_viol = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  always @(posedge clk) begin
    if (cfg_wr_en_out) begin
      w_addr_q.push_back(cfg_addr_out);
      w_data_q.push_back(cfg_wr_data_out);
      w_cyc_q.push_back(cyc);
    end
    if (cfg_rd_en_out) begin
      r_addr_q.push_back(cfg_addr_out);
      cfg_rd_data_in <= reg_val(cfg_addr_out);
    end
    if (wr_valid_in && wr_ready_out) wr_idx <= wr_idx + 1;
    if (rd_valid_out && rd_ready_in) beat_q.push_back(rd_data_out);
    if (hst_cmd_done_out) begin
      done_cyc_q.push_back(cyc);
      done_err_q.push_back(cmd_err_out);
    end
    if (hst_cmd_en_in) strobe_cyc = cyc;
    if (reset_n && prev_stall && !(rd_valid_out && rd_data_out == prev_data)) hold_viol++;
    prev_stall = reset_n && rd_valid_out && !rd_ready_in;
    prev_data  = rd_data_out;
    cyc++;
  end

  task automatic issue(input logic [7:0] addr, input logic [15:0] num);
    @(negedge clk);
    hst_cmd_en_in   = 1'b1;
    hst_addr_in     = addr;
    hst_wrrd_num_in = num;
    @(negedge clk);
    hst_cmd_en_in   = 1'b0;
  endtask

  // Bounded wait for a new done pulse; optionally toggle rd_ready_in each cycle
  task automatic wait_done(input string tag, input int base, input int budget, input bit toggle);
    int n = 0;
    while (done_cyc_q.size() <= base && n < budget) begin
      @(negedge clk);
      if (toggle) rd_ready_in = ~rd_ready_in;
      n++;
    end
    check_eq({tag, "_done_seen"}, 32'(done_cyc_q.size() > base), 32'd1);
  endtask

  int wb, rb, bb, db;

  initial begin
    for (int i = 0; i < 16; i++) wr_src[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    reset_n         = 1'b0;
    hst_cmd_en_in   = 1'b0;
    hst_addr_in     = '0;
    hst_wrrd_num_in = '0;
    rd_ready_in     = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_done", 32'(hst_cmd_done_out), 32'd0);
    check_eq("rst_wr_ready", 32'(wr_ready_out), 32'd0);
    check_eq("rst_rd_valid", 32'(rd_valid_out), 32'd0);
    check_eq("rst_cfg_addr", 32'(cfg_addr_out), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: write 3 words at 0x05, stream always valid
    wb = w_addr_q.size(); db = done_cyc_q.size();
    wr_gate = 1'b1; wr_len = 3;
    issue(8'h85, 16'd3);
    wait_done("t1", db, 40, 1'b0);
    check_eq("t1_nwr", 32'(w_addr_q.size() - wb), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("t1_addr%0d", i), 32'(w_addr_q[wb+i]), 32'h05 + 32'(i));
      check_eq($sformatf("t1_data%0d", i), w_data_q[wb+i], wr_src[i]);
      check_eq($sformatf("t1_cyc%0d", i), 32'(w_cyc_q[wb+i]), 32'(strobe_cyc + 2 + i));
    end
    check_eq("t1_done_cyc", 32'(done_cyc_q[db]), 32'(strobe_cyc + 6));
    check_eq("t1_err", 32'(done_err_q[db]), 32'd0);
    check_eq("t1_ready_low", 32'(wr_ready_out), 32'd0);

    // 2: read 2 words at 0x7F with address wrap
    rb = r_addr_q.size(); bb = beat_q.size(); db = done_cyc_q.size();
    rd_ready_in = 1'b1;
    issue(8'h7F, 16'd2);
    wait_done("t2", db, 40, 1'b0);
    check_eq("t2_nrd", 32'(r_addr_q.size() - rb), 32'd2);
    check_eq("t2_raddr0", 32'(r_addr_q[rb]), 32'h7F);
    check_eq("t2_raddr1", 32'(r_addr_q[rb+1]), 32'h00);
    check_eq("t2_nbeat", 32'(beat_q.size() - bb), 32'd2);
    check_eq("t2_beat0", beat_q[bb], reg_val(7'h7F));
    check_eq("t2_beat1", beat_q[bb+1], reg_val(7'h00));
    check_eq("t2_done_cyc", 32'(done_cyc_q[db]), 32'(strobe_cyc + 8));
    check_eq("t2_err", 32'(done_err_q[db]), 32'd0);

    // 3: zero-length read then write
    for (int k = 0; k < 2; k++) begin
      wb = w_addr_q.size(); rb = r_addr_q.size(); bb = beat_q.size(); db = done_cyc_q.size();
      issue((k == 0) ? 8'h10 : 8'h90, 16'd0);
      wait_done($sformatf("t3_%0d", k), db, 20, 1'b0);
      check_eq($sformatf("t3_%0d_done_cyc", k), 32'(done_cyc_q[db]), 32'(strobe_cyc + 2));
      check_eq($sformatf("t3_%0d_strobes", k),
               32'(w_addr_q.size() - wb + r_addr_q.size() - rb), 32'd0);
      check_eq($sformatf("t3_%0d_beats", k), 32'(beat_q.size() - bb), 32'd0);
    end

    // 4: read 4 words at 0x20 with rd_ready toggling
    bb = beat_q.size(); db = done_cyc_q.size();
    issue(8'h20, 16'd4);
    wait_done("t4", db, 80, 1'b1);
    check_eq("t4_nbeat", 32'(beat_q.size() - bb), 32'd4);
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("t4_beat%0d", i), beat_q[bb+i], reg_val(7'h20 + 7'(i)));
    check_eq("t4_hold", 32'(hold_viol), 32'd0);
    check_eq("t4_err", 32'(done_err_q[db]), 32'd0);
    rd_ready_in = 1'b1;

    // 5: write 5 words at 0x0A, stream dries up after 2 beats
    wb = w_addr_q.size(); db = done_cyc_q.size();
    wr_len = wr_idx + 2;
    issue(8'h8A, 16'd5);
    wait_done("t5", db, STALL_MAX + 100, 1'b0);
    check_eq("t5_nwr", 32'(w_addr_q.size() - wb), 32'd2);
    check_eq("t5_addr1", 32'(w_addr_q[wb+1]), 32'h0B);
    check_eq("t5_done_cyc", 32'(done_cyc_q[db]), 32'(strobe_cyc + int'(STALL_MAX) + 4));
    check_eq("t5_err", 32'(done_err_q[db]), 32'd1);
    check_eq("t5_ready_low", 32'(wr_ready_out), 32'd0);
    db = done_cyc_q.size();
    issue(8'h90, 16'd0);
    wait_done("t5b", db, 20, 1'b0);
    check_eq("t5b_err_clr", 32'(done_err_q[db]), 32'd0);

    // 6a: strobe while busy is ignored
    wb = w_addr_q.size(); bb = beat_q.size(); db = done_cyc_q.size();
    rd_ready_in = 1'b0;
    issue(8'h40, 16'd4);
    repeat (4) @(negedge clk);
    issue(8'hC0, 16'd1);
    rd_ready_in = 1'b1;
    wait_done("t6a", db, 60, 1'b0);
    repeat (10) @(negedge clk);
    check_eq("t6a_ndone", 32'(done_cyc_q.size() - db), 32'd1);
    check_eq("t6a_nwr", 32'(w_addr_q.size() - wb), 32'd0);
    check_eq("t6a_nbeat", 32'(beat_q.size() - bb), 32'd4);
    check_eq("t6a_beat3", beat_q[bb+3], reg_val(7'h43));

    // 6b: reset in the middle of a read
    db = done_cyc_q.size();
    rd_ready_in = 1'b0;
    issue(8'h50, 16'd3);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("t6b_rd_valid", 32'(rd_valid_out), 32'd0);
    check_eq("t6b_rd_data", rd_data_out, 32'd0);
    check_eq("t6b_cfg_addr", 32'(cfg_addr_out), 32'd0);
    check_eq("t6b_strobes", 32'({cfg_wr_en_out, cfg_rd_en_out, wr_ready_out}), 32'd0);
    check_eq("t6b_done", 32'({hst_cmd_done_out, cmd_err_out}), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rd_ready_in = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("t6b_no_done", 32'(done_cyc_q.size() - db), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
